coin_vend: RTL and testbench

COIN_VEND -- requirements
Module: coin_vend

---
 rtl/coin_vend.sv | 191 +++++++++++++++++++
 tb/tb_coin_vend.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_vend.sv
// Coin-operated vending controller with credit accumulation, change payout and
// a three-digit seven-segment credit display (rupees . paise tens paise units).
// Optional feature: define COIN_CANCEL_EN to enable the cancel/refund path;
// without it the cancel input is accepted but has no effect.
module coin_vend #(
    parameter int unsigned PRICE_UNITS = 4,
    parameter int unsigned MAX_UNITS   = 36
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] coin,
    input  logic       cancel,
    output logic       done,
    output logic       chg_out,
    output logic       coin_reject,
    output logic [6:0] seg_r,
    output logic [6:0] seg_t,
    output logic [6:0] seg_u
);

    localparam int unsigned CW = 6;            // credit width, holds up to 39 units
    localparam int unsigned SW = CW + 1;       // credit + coin without overflow
    localparam logic [6:0]  SEG_ZERO = 7'b1000000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] credit;
    logic [CW-1:0] credit_nxt;
    logic          reject_nxt;

    logic [CW-1:0] coin_val;
    logic          coin_valid;
    logic [SW-1:0] sum;
    logic          fits;
    logic          reaches_price;

    logic          done_nxt;
    logic          chg_nxt;
    logic [6:0]    seg_r_nxt;
    logic [6:0]    seg_t_nxt;
    logic [6:0]    seg_u_nxt;

`ifndef COIN_CANCEL_EN
    // Cancel is a no-op in this build; keep the port tied off for lint.
    logic unused_cancel;
    assign unused_cancel = cancel;
`endif

    // Active-low {g,f,e,d,c,b,a} encoding of one decimal digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Coin value decode in 25-paise units; 11 means no coin this cycle.
    always_comb begin
        coin_valid = 1'b1;
        case (coin)
            2'b00:   coin_val = CW'(1);
            2'b01:   coin_val = CW'(2);
            2'b10:   coin_val = CW'(4);
            default: begin
                coin_val   = '0;
                coin_valid = 1'b0;
            end
        endcase
    end

    // Prospective credit if the sampled coin is accepted.
    assign sum           = SW'(credit) + SW'(coin_val);
    assign fits          = (sum <= SW'(MAX_UNITS));
    assign reaches_price = (sum >= SW'(PRICE_UNITS));

    // State, credit and registered outputs; reset clears everything at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            credit      <= '0;
            done        <= 1'b0;
            chg_out     <= 1'b0;
            coin_reject <= 1'b0;
            seg_r       <= SEG_ZERO;
            seg_t       <= SEG_ZERO;
            seg_u       <= SEG_ZERO;
        end else begin
            state       <= state_nxt;
            credit      <= credit_nxt;
            done        <= done_nxt;
            chg_out     <= chg_nxt;
            coin_reject <= reject_nxt;
            seg_r       <= seg_r_nxt;
            seg_t       <= seg_t_nxt;
            seg_u       <= seg_u_nxt;
        end
    end

    // Next state, next credit and coin rejection decision.
    always_comb begin
        state_nxt  = state;
        credit_nxt = credit;
        reject_nxt = 1'b0;

        case (state)
            IDLE, COLLECT: begin
`ifdef COIN_CANCEL_EN
                // Cancel beats any simultaneous coin; full credit is refunded.
                if (cancel && (state == COLLECT)) begin
                    state_nxt  = CHANGE;
                    reject_nxt = coin_valid;
                end else
`endif
                if (coin_valid) begin
                    if (fits) begin
                        credit_nxt = sum[CW-1:0];
                        state_nxt  = reaches_price ? VEND : COLLECT;
                    end else begin
                        reject_nxt = 1'b1;
                    end
                end
            end

            VEND: begin
                credit_nxt = credit - CW'(PRICE_UNITS);
                state_nxt  = (credit_nxt != '0) ? CHANGE : IDLE;
                reject_nxt = coin_valid;
            end

            CHANGE: begin
                // One unit paid out per cycle; leave on the edge credit hits 0.
                if (credit <= CW'(1)) begin
                    credit_nxt = '0;
                    state_nxt  = IDLE;
                end else begin
                    credit_nxt = credit - CW'(1);
                end
                reject_nxt = coin_valid;
            end

            default: begin
                state_nxt  = IDLE;
                credit_nxt = '0;
            end
        endcase
    end

    // Output decode from the next state/credit so registers track the state.
    always_comb begin
        done_nxt  = (state_nxt == VEND);
        chg_nxt   = (state_nxt == CHANGE);
        seg_r_nxt = seg7(credit_nxt[CW-1:2]);
        seg_t_nxt = SEG_ZERO;
        seg_u_nxt = SEG_ZERO;
        case (credit_nxt[1:0])
            2'd1: begin
                seg_t_nxt = seg7(4'd2);
                seg_u_nxt = seg7(4'd5);
            end
            2'd2: begin
                seg_t_nxt = seg7(4'd5);
                seg_u_nxt = seg7(4'd0);
            end
            2'd3: begin
                seg_t_nxt = seg7(4'd7);
                seg_u_nxt = seg7(4'd5);
            end
            default: begin
                seg_t_nxt = SEG_ZERO;
                seg_u_nxt = SEG_ZERO;
            end
        endcase
    end

endmodule

// File: tb/tb_coin_vend.sv
// Directed testbench for coin_vend: default-price instance plus a
// PRICE_UNITS=36 / MAX_UNITS=37 instance for the credit-limit boundary.
module tb_coin_vend;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] coin, coin2;
    logic       cancel, cancel2;
    logic       done, chg_out, coin_reject;
    logic [6:0] seg_r, seg_t, seg_u;
    logic       done2, chg_out2, coin_reject2;
    logic [6:0] seg_r2, seg_t2, seg_u2;

    int vectors     = 0;
    int miscompares = 0;

    coin_vend dut (
        .clock(clock), .reset(reset), .coin(coin), .cancel(cancel),
        .done(done), .chg_out(chg_out), .coin_reject(coin_reject),
        .seg_r(seg_r), .seg_t(seg_t), .seg_u(seg_u)
    );

    coin_vend #(.PRICE_UNITS(36), .MAX_UNITS(37)) dut2 (
        .clock(clock), .reset(reset), .coin(coin2), .cancel(cancel2),
        .done(done2), .chg_out(chg_out2), .coin_reject(coin_reject2),
        .seg_r(seg_r2), .seg_t(seg_t2), .seg_u(seg_u2)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    // Expected {seg_r, seg_t, seg_u} for a credit given in 25-paise units.
    function automatic logic [20:0] disp(input int c);
        int r, f;
        r = c / 4;
        f = (c % 4) * 25;
        return {enc(r), enc(f / 10), enc(f % 10)};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; coin = 2'b11; cancel = 1'b0; coin2 = 2'b11; cancel2 = 1'b0;
        tick(); tick();
        vectors++;
        if ({done, chg_out, coin_reject} !== 3'b000 || {seg_r, seg_t, seg_u} !== disp(0)) begin
            miscompares++;
            $display("FAIL reset_state: pulses=%b disp=%h expected 000 disp=%h",
                     {done, chg_out, coin_reject}, {seg_r, seg_t, seg_u}, disp(0));
        end
        vectors++;
        if ({done2, chg_out2, coin_reject2} !== 3'b000 || {seg_r2, seg_t2, seg_u2} !== disp(0)) begin
            miscompares++;
            $display("FAIL reset_state2: pulses=%b disp=%h expected 000 disp=%h",
                     {done2, chg_out2, coin_reject2}, {seg_r2, seg_t2, seg_u2}, disp(0));
        end
        reset = 1'b0;
        tick();
        vectors++;
        if ({done, chg_out, coin_reject} !== 3'b000 || {seg_r, seg_t, seg_u} !== disp(0)) begin
            miscompares++;
            $display("FAIL reset_release: pulses=%b disp=%h expected 000 disp=%h",
                     {done, chg_out, coin_reject}, {seg_r, seg_t, seg_u}, disp(0));
        end
    endtask

    // Four 25 p coins: display steps up to 1.00 and the sale completes.
    task automatic test_quarters();
        int chg_cnt = 0;
        for (int i = 1; i <= 4; i++) begin
            coin = 2'b00;
            tick();
            vectors++;
            if ({done, chg_out, coin_reject} !== {(i == 4), 2'b00} || {seg_r, seg_t, seg_u} !== disp(i)) begin
                miscompares++;
                $display("FAIL quarters step %0d: pulses=%b disp=%h expected %b disp=%h", i,
                         {done, chg_out, coin_reject}, {seg_r, seg_t, seg_u}, {(i == 4), 2'b00}, disp(i));
            end
        end
        coin = 2'b11;
        tick();
        vectors++;
        if ({done, chg_out, coin_reject} !== 3'b000 || {seg_r, seg_t, seg_u} !== disp(0)) begin
            miscompares++;
            $display("FAIL quarters idle: pulses=%b disp=%h expected 000 disp=%h",
                     {done, chg_out, coin_reject}, {seg_r, seg_t, seg_u}, disp(0));
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (chg_out === 1'b1) chg_cnt++;
        end
        vectors++;
        if (chg_cnt !== 0) begin
            miscompares++;
            $display("FAIL quarters chg_count: got %0d expected 0", chg_cnt);
        end
    endtask

    // 50 p then 1 Rs: sale at 1.50, then two change units 0.50 -> 0.25 -> 0.00.
    task automatic test_change();
        logic [1:0] cin[5]  = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b11};
        logic [2:0] pexp[5] = '{3'b000, 3'b100, 3'b010, 3'b010, 3'b000};
        int         cexp[5] = '{2, 6, 2, 1, 0};
        int         chg_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            coin = cin[i];
            tick();
            if (chg_out === 1'b1) chg_cnt++;
            vectors++;
            if ({done, chg_out, coin_reject} !== pexp[i] || {seg_r, seg_t, seg_u} !== disp(cexp[i])) begin
                miscompares++;
                $display("FAIL change step %0d: pulses=%b disp=%h expected %b disp=%h", i,
                         {done, chg_out, coin_reject}, {seg_r, seg_t, seg_u}, pexp[i], disp(cexp[i]));
            end
        end
        vectors++;
        if (chg_cnt !== 2) begin
            miscompares++;
            $display("FAIL change chg_count: got %0d expected 2", chg_cnt);
        end
    endtask

    // A 1 Rs coin dropped while change is paid out is rejected.
    task automatic test_reject_in_change();
        logic [1:0] cin[5]  = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b11};
        logic [2:0] pexp[5] = '{3'b000, 3'b100, 3'b010, 3'b011, 3'b000};
        int         cexp[5] = '{2, 6, 2, 1, 0};
        int         chg_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            coin = cin[i];
            tick();
            if (chg_out === 1'b1) chg_cnt++;
            vectors++;
            if ({done, chg_out, coin_reject} !== pexp[i] || {seg_r, seg_t, seg_u} !== disp(cexp[i])) begin
                miscompares++;
                $display("FAIL reject_in_change step %0d: pulses=%b disp=%h expected %b disp=%h", i,
                         {done, chg_out, coin_reject}, {seg_r, seg_t, seg_u}, pexp[i], disp(cexp[i]));
            end
        end
        vectors++;
        if (chg_cnt !== 2) begin
            miscompares++;
            $display("FAIL reject_in_change chg_count: got %0d expected 2", chg_cnt);
        end
    endtask

    // Consecutive 1 Rs coins: the one landing in VEND is rejected, the next sells.
    task automatic test_back_to_back();
        logic [1:0] cin[4]  = '{2'b10, 2'b10, 2'b10, 2'b11};
        logic [2:0] pexp[4] = '{3'b100, 3'b001, 3'b100, 3'b000};
        int         cexp[4] = '{4, 0, 4, 0};
        for (int i = 0; i < 4; i++) begin
            coin = cin[i];
            tick();
            vectors++;
            if ({done, chg_out, coin_reject} !== pexp[i] || {seg_r, seg_t, seg_u} !== disp(cexp[i])) begin
                miscompares++;
                $display("FAIL back_to_back step %0d: pulses=%b disp=%h expected %b disp=%h", i,
                         {done, chg_out, coin_reject}, {seg_r, seg_t, seg_u}, pexp[i], disp(cexp[i]));
            end
        end
    endtask

`ifdef COIN_CANCEL_EN
    // Cancel with a coin in COLLECT: coin rejected, 3 units refunded, no sale.
    task automatic test_cancel();
        logic [1:0] cin[6]  = '{2'b00, 2'b01, 2'b00, 2'b11, 2'b11, 2'b11};
        logic       cxl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [2:0] pexp[6] = '{3'b000, 3'b000, 3'b011, 3'b010, 3'b010, 3'b000};
        int         cexp[6] = '{1, 3, 3, 2, 1, 0};
        int         chg_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            coin = cin[i]; cancel = cxl[i];
            tick();
            if (chg_out === 1'b1) chg_cnt++;
            vectors++;
            if ({done, chg_out, coin_reject} !== pexp[i] || {seg_r, seg_t, seg_u} !== disp(cexp[i])) begin
                miscompares++;
                $display("FAIL cancel step %0d: pulses=%b disp=%h expected %b disp=%h", i,
                         {done, chg_out, coin_reject}, {seg_r, seg_t, seg_u}, pexp[i], disp(cexp[i]));
            end
        end
        cancel = 1'b0;
        vectors++;
        if (chg_cnt !== 3) begin
            miscompares++;
            $display("FAIL cancel chg_count: got %0d expected 3", chg_cnt);
        end
    endtask
`else
    // Cancel held high throughout has no effect: coins accepted, normal sale.
    task automatic test_cancel();
        logic [1:0] cin[4]  = '{2'b00, 2'b01, 2'b00, 2'b11};
        logic [2:0] pexp[4] = '{3'b000, 3'b000, 3'b100, 3'b000};
        int         cexp[4] = '{1, 3, 4, 0};
        cancel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            coin = cin[i];
            tick();
            vectors++;
            if ({done, chg_out, coin_reject} !== pexp[i] || {seg_r, seg_t, seg_u} !== disp(cexp[i])) begin
                miscompares++;
                $display("FAIL cancel_ignored step %0d: pulses=%b disp=%h expected %b disp=%h", i,
                         {done, chg_out, coin_reject}, {seg_r, seg_t, seg_u}, pexp[i], disp(cexp[i]));
            end
        end
        cancel = 1'b0;
    endtask
`endif

    // Price 36 / max 37: at 34 a 1 Rs coin overflows and is rejected, 50 p sells.
    task automatic test_max_credit();
        logic [1:0] cin[4]  = '{2'b01, 2'b10, 2'b11, 2'b01};
        logic [2:0] pexp[4] = '{3'b000, 3'b001, 3'b000, 3'b100};
        int         cexp[4] = '{34, 34, 34, 36};
        for (int i = 0; i < 8; i++) begin
            coin2 = 2'b10;
            tick();
        end
        vectors++;
        if ({done2, chg_out2, coin_reject2} !== 3'b000 || {seg_r2, seg_t2, seg_u2} !== disp(32)) begin
            miscompares++;
            $display("FAIL max_credit at32: pulses=%b disp=%h expected 000 disp=%h",
                     {done2, chg_out2, coin_reject2}, {seg_r2, seg_t2, seg_u2}, disp(32));
        end
        for (int i = 0; i < 4; i++) begin
            coin2 = cin[i];
            tick();
            vectors++;
            if ({done2, chg_out2, coin_reject2} !== pexp[i] || {seg_r2, seg_t2, seg_u2} !== disp(cexp[i])) begin
                miscompares++;
                $display("FAIL max_credit step %0d: pulses=%b disp=%h expected %b disp=%h", i,
                         {done2, chg_out2, coin_reject2}, {seg_r2, seg_t2, seg_u2}, pexp[i], disp(cexp[i]));
            end
        end
        coin2 = 2'b11;
        tick();
        vectors++;
        if ({done2, chg_out2, coin_reject2} !== 3'b000 || {seg_r2, seg_t2, seg_u2} !== disp(0)) begin
            miscompares++;
            $display("FAIL max_credit idle: pulses=%b disp=%h expected 000 disp=%h",
                     {done2, chg_out2, coin_reject2}, {seg_r2, seg_t2, seg_u2}, disp(0));
        end
    endtask

    // Reset between edges while 2 change units are pending clears everything.
    task automatic test_reset_mid_change();
        logic [1:0] cin[3] = '{2'b01, 2'b10, 2'b11};
        int         pulses = 0;
        for (int i = 0; i < 3; i++) begin
            coin = cin[i];
            tick();
        end
        vectors++;
        if ({done, chg_out, coin_reject} !== 3'b010 || {seg_r, seg_t, seg_u} !== disp(2)) begin
            miscompares++;
            $display("FAIL rst_change setup: pulses=%b disp=%h expected 010 disp=%h",
                     {done, chg_out, coin_reject}, {seg_r, seg_t, seg_u}, disp(2));
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({done, chg_out, coin_reject} !== 3'b000 || {seg_r, seg_t, seg_u} !== disp(0)) begin
            miscompares++;
            $display("FAIL rst_change async: pulses=%b disp=%h expected 000 disp=%h",
                     {done, chg_out, coin_reject}, {seg_r, seg_t, seg_u}, disp(0));
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (chg_out === 1'b1 || done === 1'b1 || coin_reject === 1'b1) pulses++;
        end
        vectors++;
        if (pulses !== 0 || {seg_r, seg_t, seg_u} !== disp(0)) begin
            miscompares++;
            $display("FAIL rst_change after: pulse_cycles=%0d disp=%h expected 0 disp=%h",
                     pulses, {seg_r, seg_t, seg_u}, disp(0));
        end
    endtask

    initial begin
        test_reset();
        test_quarters();
        test_change();
        test_reject_in_change();
        test_back_to_back();
        test_cancel();
        test_max_credit();
        test_reset_mid_change();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
